corr_pkt_unpack: RTL and testbench



---
 rtl/corr_pkt_unpack.sv | 133 +++++++++++++
 tb/tb_corr_pkt_unpack.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/corr_pkt_unpack.sv
// Reassembles 5-byte correlator result packets into parallel records and
// tracks window-number continuity with a saturating dropped-window counter.
//
// idx_q | meaning
// 0     | waiting for window number
// 1     | waiting for countX
// 2     | waiting for countY
// 3     | waiting for countIsect
// 4     | waiting for countSymdiff (frame completes on acceptance)
module corr_pkt_unpack #(
   parameter int NDROP_W = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_cg,
   input  logic [7:0]         i_bp_data,
   input  logic               i_bp_valid,
   output logic               o_bp_ready,
   output logic [7:0]         o_winNum,
   output logic [7:0]         o_countX,
   output logic [7:0]         o_countY,
   output logic [7:0]         o_countIsect,
   output logic [7:0]         o_countSymdiff,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [NDROP_W-1:0] o_nDropped,
   output logic               o_gap,
   input  logic               i_clearDropped
);

   localparam int SUM_W = ((NDROP_W > 8) ? NDROP_W : 8) + 1;

   logic [2:0]         idx_q;
   logic [7:0]         sh_win_q;
   logic [7:0]         sh_x_q;
   logic [7:0]         sh_y_q;
   logic [7:0]         sh_isect_q;
   logic               valid_q;
   logic               have_last_q;
   logic [7:0]         last_win_q;
   logic [NDROP_W-1:0] n_dropped_q;
   logic               gap_q;

   logic               accept;
   logic               complete;
   logic               consume;
   logic               clear;
   logic               seq_gap;
   logic [7:0]         gap_len;
   logic [SUM_W-1:0]   drop_sum;
   logic [NDROP_W-1:0] drop_next;

   // The last byte is the only one that needs a free output slot; earlier
   // bytes land in shadow registers and never stall.
   assign o_bp_ready = i_cg && ((idx_q != 3'd4) || !valid_q || i_ready);
   assign accept     = i_bp_valid && o_bp_ready;
   assign complete   = accept && (idx_q == 3'd4);
   assign o_valid    = valid_q && i_cg;
   assign consume    = o_valid && i_ready;
   assign clear      = i_cg && i_clearDropped;

   // Modular distance; zero means the window numbers are consecutive, and a
   // repeated number wraps to 255 skipped windows.
   assign gap_len   = sh_win_q - last_win_q - 8'd1;
   assign seq_gap   = complete && have_last_q && (gap_len != 8'd0) && !clear;
   assign drop_sum  = SUM_W'(n_dropped_q) + SUM_W'(gap_len);
   assign drop_next = (|drop_sum[SUM_W-1:NDROP_W]) ? '1 : drop_sum[NDROP_W-1:0];

   assign o_nDropped = n_dropped_q;
   assign o_gap      = gap_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         idx_q          <= 3'd0;
         sh_win_q       <= 8'd0;
         sh_x_q         <= 8'd0;
         sh_y_q         <= 8'd0;
         sh_isect_q     <= 8'd0;
         valid_q        <= 1'b0;
         have_last_q    <= 1'b0;
         last_win_q     <= 8'd0;
         n_dropped_q    <= '0;
         gap_q          <= 1'b0;
         o_winNum       <= 8'd0;
         o_countX       <= 8'd0;
         o_countY       <= 8'd0;
         o_countIsect   <= 8'd0;
         o_countSymdiff <= 8'd0;
      end else begin
         // Pulse only; seq_gap already requires i_cg, so it reads 0 while gated.
         gap_q <= seq_gap;

         if (i_cg) begin
            if (accept) begin
               case (idx_q)
                  3'd0:    sh_win_q   <= i_bp_data;
                  3'd1:    sh_x_q     <= i_bp_data;
                  3'd2:    sh_y_q     <= i_bp_data;
                  3'd3:    sh_isect_q <= i_bp_data;
                  default: ;
               endcase
               idx_q <= (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
            end

            if (complete) begin
               o_winNum       <= sh_win_q;
               o_countX       <= sh_x_q;
               o_countY       <= sh_y_q;
               o_countIsect   <= sh_isect_q;
               o_countSymdiff <= i_bp_data;
               valid_q        <= 1'b1;
            end else if (consume) begin
               valid_q <= 1'b0;
            end

            if (clear) begin
               n_dropped_q <= '0;
            end else if (seq_gap) begin
               n_dropped_q <= drop_next;
            end

            // A completing frame always becomes the new baseline, even on clear.
            if (complete) begin
               last_win_q  <= sh_win_q;
               have_last_q <= 1'b1;
            end else if (clear) begin
               have_last_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_corr_pkt_unpack.sv
// Scoreboard bench for corr_pkt_unpack: records are queued as frames are sent
// and compared when the consumer handshake takes them.
module tb_corr_pkt_unpack;

   typedef struct {
      logic [7:0] w;
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] i;
      logic [7:0] s;
   } rec_t;

   logic       clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_cg = 1'b1;
   logic [7:0] i_bp_data = 8'd0;
   logic       i_bp_valid = 1'b0;
   logic       o_bp_ready;
   logic [7:0] o_winNum, o_countX, o_countY, o_countIsect, o_countSymdiff;
   logic       o_valid;
   logic       i_ready = 1'b1;
   logic [3:0] o_nDropped;
   logic       o_gap;
   logic       i_clearDropped = 1'b0;

   int   n_vec = 0;
   int   n_err = 0;
   rec_t sb[$];
   int   gap_seen = 0;
   int   exp_gaps = 0;

   int         m_ndrop = 0;
   bit         m_have = 0;
   logic [7:0] m_last = 8'd0;

   corr_pkt_unpack #(.NDROP_W(4)) dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_cg(i_cg),
      .i_bp_data(i_bp_data), .i_bp_valid(i_bp_valid), .o_bp_ready(o_bp_ready),
      .o_winNum(o_winNum), .o_countX(o_countX), .o_countY(o_countY),
      .o_countIsect(o_countIsect), .o_countSymdiff(o_countSymdiff),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_nDropped(o_nDropped), .o_gap(o_gap), .i_clearDropped(i_clearDropped)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      rec_t e;
      if (o_gap) gap_seen++;
      if (i_rst_n && o_valid && i_ready) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL rec_unexpected: got w=%h x=%h, required no record", o_winNum, o_countX);
         end else begin
            e = sb.pop_front();
            if ({o_winNum, o_countX, o_countY, o_countIsect, o_countSymdiff} !== {e.w, e.x, e.y, e.i, e.s}) begin
               n_err++;
               $display("FAIL rec_fields: got %h %h %h %h %h, required %h %h %h %h %h",
                        o_winNum, o_countX, o_countY, o_countIsect, o_countSymdiff, e.w, e.x, e.y, e.i, e.s);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, output int wt);
      bit ok = 0;
      wt = 0;
      i_bp_data  = b;
      i_bp_valid = 1'b1;
      while (wt < 40) begin
         @(negedge clk);
         ok = o_bp_ready;
         @(posedge clk);
         #1;
         if (ok) break;
         wt++;
      end
      i_bp_valid = 1'b0;
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL byte_timeout: byte %h not accepted within 40 cycles", b);
      end
   endtask

   task automatic send_frame(input logic [7:0] w, x, y, is, sd, input bit clr, output int waits);
      logic [7:0] b[5];
      rec_t r;
      int   wt;
      int   g;
      bit   exp_gap;
      b = '{w, x, y, is, sd};
      r.w = w; r.x = x; r.y = y; r.i = is; r.s = sd;
      sb.push_back(r);
      g = int'(w) - int'(m_last) - 1;
      if (g < 0) g += 256;
      exp_gap = 0;
      if (clr) m_ndrop = 0;
      else if (m_have && g != 0) begin
         m_ndrop = (m_ndrop + g > 15) ? 15 : m_ndrop + g;
         exp_gap = 1;
         exp_gaps++;
      end
      m_last = w;
      m_have = 1;
      waits = 0;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) i_clearDropped = clr;
         send_byte(b[k], wt);
         waits += wt;
      end
      i_clearDropped = 1'b0;
      n_vec++;
      if (o_valid !== 1'b1) begin
         n_err++; $display("FAIL frame_valid w=%h: got %b, required 1", w, o_valid);
      end
      n_vec++;
      if (o_gap !== exp_gap) begin
         n_err++; $display("FAIL frame_gap w=%h: got %b, required %b", w, o_gap, exp_gap);
      end
      n_vec++;
      if (o_nDropped !== m_ndrop[3:0]) begin
         n_err++; $display("FAIL frame_ndrop w=%h: got %0d, required %0d", w, o_nDropped, m_ndrop);
      end
   endtask

   task automatic do_clear();
      i_clearDropped = 1'b1;
      @(posedge clk); #1;
      i_clearDropped = 1'b0;
      m_ndrop = 0;
      m_have  = 0;
      n_vec++;
      if (o_nDropped !== 4'd0) begin
         n_err++; $display("FAIL clear_ndrop: got %0d, required 0", o_nDropped);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({o_valid, o_gap, o_nDropped, o_winNum, o_countX, o_countY, o_countIsect, o_countSymdiff} !== '0) begin
         n_err++; $display("FAIL reset_outputs: got v=%b g=%b n=%0d w=%h, required all 0", o_valid, o_gap, o_nDropped, o_winNum);
      end
      n_vec++;
      if (o_bp_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_ready_cg1: got %b, required 1", o_bp_ready);
      end
      i_cg = 1'b0;
      #1;
      n_vec++;
      if (o_bp_ready !== 1'b0) begin
         n_err++; $display("FAIL reset_ready_cg0: got %b, required 0", o_bp_ready);
      end
      i_cg = 1'b1;
      i_rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_frame();
      int w;
      send_frame(8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 0, w);
   endtask

   task automatic test_gap();
      int w;
      do_clear();
      send_frame(8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 0, w);
      send_frame(8'h08, 8'h05, 8'h06, 8'h07, 8'h08, 0, w);
      send_frame(8'h09, 8'h09, 8'h0A, 8'h0B, 8'h0C, 0, w);
   endtask

   task automatic test_wrap();
      int w;
      do_clear();
      send_frame(8'hFE, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 0, w);
      send_frame(8'hFF, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 0, w);
      send_frame(8'h00, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 0, w);
      send_frame(8'h01, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 0, w);
   endtask

   task automatic test_back_to_back();
      int  w;
      int  total = 0;
      time t0;
      do_clear();
      t0 = $time;
      for (int f = 0; f < 3; f++) begin
         send_frame(8'h50 + 8'(f), 8'(f * 3), 8'hE0, 8'h5A, 8'(f), 0, w);
         total += w;
      end
      n_vec++;
      if (total != 0 || ($time - t0) != 150) begin
         n_err++; $display("FAIL b2b_throughput: got %0d waits in %0t, required 0 waits in 150", total, $time - t0);
      end
   endtask

   task automatic test_backpressure();
      int w;
      do_clear();
      send_frame(8'h10, 8'h61, 8'h62, 8'h63, 8'h64, 0, w);
      i_ready = 1'b0;
      fork
         send_frame(8'h11, 8'h71, 8'h72, 8'h73, 8'h74, 0, w);
         begin
            repeat (6) @(posedge clk);
            #1;
            n_vec++;
            if (o_bp_ready !== 1'b0 || o_valid !== 1'b1 || o_winNum !== 8'h10 || sb.size() != 2) begin
               n_err++;
               $display("FAIL bp_stall: got rdy=%b v=%b w=%h q=%0d, required rdy=0 v=1 w=10 q=2",
                        o_bp_ready, o_valid, o_winNum, sb.size());
            end
            i_ready = 1'b1;
         end
      join
      n_vec++;
      if (w != 2) begin
         n_err++; $display("FAIL bp_waits: got %0d, required 2", w);
      end
   endtask

   task automatic test_sat_clear();
      int w;
      do_clear();
      send_frame(8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 0, w);
      send_frame(8'h20, 8'h02, 8'h02, 8'h02, 8'h02, 0, w);
      send_frame(8'h30, 8'h03, 8'h03, 8'h03, 8'h03, 1, w);
      send_frame(8'h32, 8'h04, 8'h04, 8'h04, 8'h04, 0, w);
      send_frame(8'h32, 8'h05, 8'h05, 8'h05, 8'h05, 0, w);
   endtask

   task automatic test_clock_gate();
      int w;
      do_clear();
      i_ready = 1'b0;
      send_frame(8'h40, 8'h81, 8'h82, 8'h83, 8'h84, 0, w);
      i_cg = 1'b0;
      i_ready = 1'b1;
      i_bp_data = 8'hEE;
      i_bp_valid = 1'b1;
      #1;
      n_vec++;
      if (o_bp_ready !== 1'b0 || o_valid !== 1'b0) begin
         n_err++; $display("FAIL cg_outputs: got rdy=%b v=%b, required 0 0", o_bp_ready, o_valid);
      end
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (sb.size() != 1 || o_gap !== 1'b0 || o_nDropped !== 4'd0) begin
         n_err++; $display("FAIL cg_frozen: got q=%0d gap=%b n=%0d, required q=1 gap=0 n=0", sb.size(), o_gap, o_nDropped);
      end
      i_bp_valid = 1'b0;
      i_cg = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (sb.size() != 0 || o_valid !== 1'b0) begin
         n_err++; $display("FAIL cg_resume: got q=%0d v=%b, required q=0 v=0", sb.size(), o_valid);
      end
      send_frame(8'h41, 8'h91, 8'h92, 8'h93, 8'h94, 0, w);
   endtask

   task automatic test_reset_mid_frame();
      int w;
      repeat (2) @(posedge clk);
      #1;
      send_byte(8'h01, w);
      send_byte(8'h02, w);
      i_rst_n = 1'b0;
      @(posedge clk); #1;
      i_rst_n = 1'b1;
      m_ndrop = 0;
      m_have  = 0;
      n_vec++;
      if (o_valid !== 1'b0 || o_nDropped !== 4'd0) begin
         n_err++; $display("FAIL rst_mid: got v=%b n=%0d, required 0 0", o_valid, o_nDropped);
      end
      send_frame(8'h07, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 0, w);
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_gap();
      test_wrap();
      test_back_to_back();
      test_backpressure();
      test_sat_clear();
      test_clock_gate();
      test_reset_mid_frame();
      repeat (5) @(posedge clk);
      #1;
      n_vec++;
      if (sb.size() != 0) begin
         n_err++; $display("FAIL sb_drain: got %0d records left, required 0", sb.size());
      end
      n_vec++;
      if (gap_seen != exp_gaps) begin
         n_err++; $display("FAIL gap_pulses: got %0d, required %0d", gap_seen, exp_gaps);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
